// File: rtl/iob_eth_rx_pkg.sv
// Shared definitions for the MII receive deframer: FSM states, delimiter nibbles,
// minimum frame length and CRC-32 constants/helpers.
package iob_eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    localparam logic [3:0]  PRE_NIB       = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;
    localparam int unsigned MIN_FRAME_LEN = 64;

    // Reflected form of polynomial 0x04C11DB7; residue is the reflected 0xC704DD7B.
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/iob_eth_rx_fifo.sv
// Synchronous FIFO for deframer entries; a push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module iob_eth_rx_fifo #(
    parameter int unsigned WIDTH   = 26,
    parameter int unsigned DEPTH_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned DEPTH = 1 << DEPTH_W;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [DEPTH_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH_W:0]   cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign full  = (cnt_q == (DEPTH_W + 1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign rdata = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iob_eth_mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes and queues them
// with per-frame length/error status. FCS checking is built when IOB_ETH_RX_FCS_CHECK_EN is defined.
module iob_eth_mii_rx_deframer
    import iob_eth_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_W = 4,
    parameter int unsigned LEN_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mii_clk,
    input  logic [3:0]       mii_data,
    input  logic             mii_dv,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_eof,
    output logic             m_err,
    output logic [LEN_W-1:0] m_len,
    output logic             overflow
);
    logic             clk_s1_q, clk_s2_q, clk_s3_q, strobe_q;
    logic [3:0]       data_s1_q, data_s2_q, data_s3_q;
    logic             dv_s1_q, dv_s2_q, dv_s3_q;
    rx_state_e        state_q, state_d;
    logic [3:0]       low_q, low_d;
    logic             half_q, half_d;
    logic [7:0]       held_q, held_d;
    logic             have_q, have_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
    logic             push, push_eof, push_err, fcs_err;
    logic [LEN_W-1:0] push_len;
    logic             fifo_full, fifo_empty, pop;
    logic [LEN_W+9:0] fifo_rdata;

    // Data/dv ride one extra stage so they line up with the registered edge strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q  <= 1'b0;
            clk_s2_q  <= 1'b0;
            clk_s3_q  <= 1'b0;
            strobe_q  <= 1'b0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            data_s3_q <= '0;
            dv_s1_q   <= 1'b0;
            dv_s2_q   <= 1'b0;
            dv_s3_q   <= 1'b0;
        end else begin
            clk_s1_q  <= mii_clk;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            strobe_q  <= clk_s2_q & ~clk_s3_q;
            data_s1_q <= mii_data;
            data_s2_q <= data_s1_q;
            data_s3_q <= data_s2_q;
            dv_s1_q   <= mii_dv;
            dv_s2_q   <= dv_s1_q;
            dv_s3_q   <= dv_s2_q;
        end
    end

`ifdef IOB_ETH_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d;
    assign fcs_err = (crc_q != CRC_RESIDUE);
`else
    assign fcs_err = 1'b0;
`endif

    assign pop = m_valid & m_ready;

    always_comb begin
        state_d    = state_q;
        low_d      = low_q;
        half_d     = half_q;
        held_d     = held_q;
        have_d     = have_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        push_eof   = 1'b0;
        push_err   = 1'b0;
        push_len   = '0;
`ifdef IOB_ETH_RX_FCS_CHECK_EN
        crc_d      = crc_q;
`endif
        if (strobe_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dv_s3_q) begin
                        state_d = (data_s3_q == PRE_NIB) ? ST_PREAMBLE : ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!dv_s3_q) begin
                        state_d = ST_IDLE;
                    end else if (data_s3_q == SFD_NIB) begin
                        state_d = ST_DATA;
                        half_d  = 1'b0;
                        have_d  = 1'b0;
                        cnt_d   = '0;
`ifdef IOB_ETH_RX_FCS_CHECK_EN
                        crc_d   = CRC_INIT;
`endif
                    end else if (data_s3_q != PRE_NIB) begin
                        state_d = ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!dv_s3_q) begin
                        state_d = ST_IDLE;
                        if (have_q) begin
                            push     = 1'b1;
                            push_eof = 1'b1;
                            push_len = cnt_q;
                            push_err = half_q | (cnt_q < LEN_W'(MIN_FRAME_LEN)) | fcs_err;
                        end
                    end else if (!half_q) begin
                        low_d  = data_s3_q;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        push   = have_q;
                        held_d = {data_s3_q, low_q};
                        have_d = 1'b1;
                        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`ifdef IOB_ETH_RX_FCS_CHECK_EN
                        crc_d  = crc32_byte(crc_q, {data_s3_q, low_q});
`endif
                    end
                end
                ST_DROP: begin
                    if (!dv_s3_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // No room: discard the push and abandon the rest of the frame.
            if (push && fifo_full && !pop) begin
                push       = 1'b0;
                overflow_d = 1'b1;
                have_d     = 1'b0;
                state_d    = ST_DROP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            low_q      <= '0;
            half_q     <= 1'b0;
            held_q     <= '0;
            have_q     <= 1'b0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
`ifdef IOB_ETH_RX_FCS_CHECK_EN
            crc_q      <= CRC_INIT;
`endif
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            half_q     <= half_d;
            held_q     <= held_d;
            have_q     <= have_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
`ifdef IOB_ETH_RX_FCS_CHECK_EN
            crc_q      <= crc_d;
`endif
        end
    end

    iob_eth_rx_fifo #(
        .WIDTH  (LEN_W + 10),
        .DEPTH_W(FIFO_DEPTH_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata({push_eof, push_err, push_len, held_q}),
        .pop  (pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign m_valid  = ~fifo_empty;
    assign m_data   = fifo_rdata[7:0];
    assign m_len    = fifo_rdata[LEN_W+7:8];
    assign m_err    = fifo_rdata[LEN_W+8];
    assign m_eof    = fifo_rdata[LEN_W+9];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_iob_eth_mii_rx_deframer.sv
// Directed bench for iob_eth_mii_rx_deframer: drives MII frames nibble by nibble and
// checks the delivered byte stream, frame status and overflow flag.
module tb_iob_eth_mii_rx_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mii_clk = 1'b0;
    logic [3:0]  mii_data = '0;
    logic        mii_dv = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_eof;
    logic        m_err;
    logic [15:0] m_len;
    logic        overflow;

    typedef struct {
        logic [7:0]  d;
        logic        eof;
        logic        err;
        logic [15:0] len;
    } rx_t;

    rx_t        rxq[$];
    logic [7:0] frm[$];
    int         checks = 0;
    int         errors = 0;

`ifdef IOB_ETH_RX_FCS_CHECK_EN
    localparam logic FCS_BAD_ERR = 1'b1;
`else
    localparam logic FCS_BAD_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    iob_eth_mii_rx_deframer #(
        .FIFO_DEPTH_W(4),
        .LEN_W       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mii_clk (mii_clk),
        .mii_data(mii_data),
        .mii_dv  (mii_dv),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_eof   (m_eof),
        .m_err   (m_err),
        .m_len   (m_len),
        .overflow(overflow)
    );

    // Inputs change 2 time units after posedge; transfers are captured mid-cycle.
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            rxq.push_back('{d: m_data, eof: m_eof, err: m_err, len: m_len});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_nib(input logic dv, input logic [3:0] n);
        mii_dv   = dv;
        mii_data = n;
        mii_clk  = 1'b0;
        tick();
        tick();
        mii_clk  = 1'b1;
        tick();
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(1'b1, b[3:0]);
        send_nib(1'b1, b[7:4]);
    endtask

    task automatic send_idle();
        for (int i = 0; i < 4; i++) send_nib(1'b0, 4'h0);
        repeat (8) tick();
    endtask

    // Payload of n bytes followed by its Ethernet FCS, least significant byte first.
    task automatic build(input int n, input logic [7:0] seed);
        logic [31:0] crc;
        logic [7:0]  b;
        frm.delete();
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = 8'(i * 13) + seed;
            frm.push_back(b);
            crc = crc ^ {24'h0, b};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        frm.push_back(crc[7:0]);
        frm.push_back(crc[15:8]);
        frm.push_back(crc[23:16]);
        frm.push_back(crc[31:24]);
    endtask

    task automatic send_frame(input logic extra_nib);
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        foreach (frm[i]) send_byte(frm[i]);
        if (extra_nib) send_nib(1'b1, 4'h6);
        send_idle();
    endtask

    task automatic check_frame(input string tag, input int n_exp, input logic with_eof,
                               input int len_exp, input logic err_exp);
        check({tag, "_count"}, rxq.size(), n_exp);
        for (int i = 0; i < n_exp && i < rxq.size(); i++) begin
            check({tag, "_data"}, rxq[i].d, frm[i]);
            check({tag, "_eof"}, rxq[i].eof, with_eof && (i == n_exp - 1));
        end
        if (with_eof && rxq.size() == n_exp) begin
            check({tag, "_len"}, rxq[n_exp-1].len, len_exp);
            check({tag, "_err"}, rxq[n_exp-1].err, err_exp);
        end
        rxq.delete();
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_eof", m_eof, 0);
        check("rst_err", m_err, 0);
        check("rst_len", m_len, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b1;
        repeat (2) tick();
        m_ready = 1'b1;

        build(60, 8'h11);
        send_frame(1'b0);
        check_frame("good64", 64, 1'b1, 64, 1'b0);

        build(60, 8'h22);
        frm[60] = frm[60] ^ 8'hFF;
        send_frame(1'b0);
        check_frame("badfcs", 64, 1'b1, 64, FCS_BAD_ERR);

        build(16, 8'h33);
        send_frame(1'b0);
        check_frame("runt20", 20, 1'b1, 20, 1'b1);

        build(60, 8'h44);
        send_frame(1'b1);
        check_frame("oddnib", 64, 1'b1, 64, 1'b1);

        m_ready = 1'b0;
        build(60, 8'h55);
        send_frame(1'b0);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", m_valid, 1);
        check("ovf_held", rxq.size(), 0);
        m_ready = 1'b1;
        repeat (24) tick();
        check_frame("ovf_drain", 16, 1'b0, 0, 1'b0);
        build(60, 8'h66);
        send_frame(1'b0);
        check_frame("after_ovf", 64, 1'b1, 64, 1'b0);
        check("ovf_sticky", overflow, 1);

        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'h35);
        for (int i = 0; i < 10; i++) send_byte((i % 2 == 0) ? 8'h55 : 8'hD5);
        send_idle();
        check("badpre_none", rxq.size(), 0);
        check("badpre_valid", m_valid, 0);
        build(60, 8'h77);
        send_frame(1'b0);
        check_frame("after_badpre", 64, 1'b1, 64, 1'b0);
        check("end_valid", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_eth_mii_rx_deframer.md
# iob_eth_mii_rx_deframer

Simulation-side MII receive deframer that consumes the transmit nibble stream emitted by the system's ETHERNET0 instance (TX_CLK/TX_DATA/TX_EN) and turns it into a byte stream with frame delimiters and status. It strips preamble/SFD, assembles nibbles into bytes, buffers them in a small FIFO, and reports length, alignment, overflow and (optionally) FCS errors per frame. It sits directly downstream of the system's Ethernet TX pins, in parallel with the loopback generator, and feeds the bench's frame checker.

## Interface
- FIFO_DEPTH_W, 4, log2 of byte FIFO depth (16 entries)
- LEN_W, 16, width of frame length counter
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  asynchronous, active-low reset
- mii_clk  input  1  Ethernet clock (4x slower than clk), sampled as data
- mii_data  input  4  MII nibble, low nibble of each byte first
- mii_dv  input  1  MII data valid (TX_EN of the system)
- m_valid  output  1  byte available
- m_ready  input  1  consumer accepts byte
- m_data  output  8  frame byte (destination MAC first, FCS last)
- m_eof  output  1  current byte is the last of its frame
- m_err  output  1  frame error; meaningful only with m_eof
- m_len  output  LEN_W  byte count of frame incl. FCS; meaningful only with m_eof
- overflow  output  1  sticky; set when a frame was dropped for lack of FIFO space

## Operation
- mii_clk, mii_data, mii_dv pass through a 2-flop synchronizer; a rising edge of synchronized mii_clk produces a one-cycle sample strobe; all MII state advances only on the strobe.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE: dv=1 and nibble 0x5 -> PREAMBLE; dv=1 other nibble -> DROP.
- PREAMBLE: nibble 0x5 stays; nibble 0xD -> DATA (SFD 0xD5 complete); other nibble -> DROP; dv=0 -> IDLE, nothing emitted.
- DATA: even nibble -> low half; odd nibble -> byte complete, stored in a one-byte holding register; the previous held byte is pushed with eof=0. Length counter increments per completed byte, saturating at all-ones.
- DATA, dv=0: held byte pushed with eof=1, m_len=count, m_err = odd-nibble alignment error OR length < 64 OR FCS error; -> IDLE. dv falling with zero completed bytes: nothing pushed, -> IDLE.
- DROP: waits for dv=0 -> IDLE; no pushes.
- Push with FIFO full: overflow<=1, FSM -> DROP; bytes of that frame already queued remain, so consumer sees a frame without eof until the next frame's bytes; bench treats overflow as fatal.
- FIFO entry = {eof, err, len, data}; m_* driven directly from FIFO head.

## Timing
- Reset: m_valid=0, m_data=0, m_eof=0, m_err=0, m_len=0, overflow=0, FSM=IDLE, FIFO empty, synchronizers 0.
- Sample strobe asserted 3 clk cycles after mii_clk rises (2 sync + edge register).
- A byte becomes visible on m_valid 1 cycle after the strobe that completes the following byte (or the dv-low strobe for the last byte).
- Handshake: transfer when m_valid & m_ready; m_valid/m_data stable until transfer; simultaneous push and pop on full FIFO is accepted (no overflow).
- Reset mid-frame: FIFO flushed, FSM IDLE; the rest of that frame is consumed in DROP only if dv is still high after reset release (IDLE sees non-0x5 data nibble) — otherwise a 0x5 payload nibble can false-start; bench releases reset with dv=0.

## Configuration
- IOB_ETH_RX_FCS_CHECK_EN defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) updated per completed byte over all post-SFD bytes incl. FCS; FCS error when final residue != 0xDEBB20E3 (reflected form of 0xC704DD7B). Counts into m_err.
- Undefined: no CRC logic; FCS contributes 0 to m_err; FCS bytes still delivered.

## Structure
- Shared package (iob_eth_rx_pkg / header): FSM state encodings, preamble/SFD nibble constants, MIN_FRAME_LEN=64, CRC polynomial and residue constants.
- One sub-module: iob_eth_rx_fifo (synchronous FIFO, width 10+LEN_W, depth 2^FIFO_DEPTH_W, full/empty flags).

## Test plan
- 7x 0x55 + 0xD5 + 60-byte payload + correct 4-byte FCS, m_ready=1 -> 64 bytes out, eof on byte 64, m_len=64, m_err=0.
- Same frame with FCS byte 0 flipped -> m_err=1 with FCS check enabled; m_err=0 with it disabled.
- 20-byte frame (FCS valid) -> m_len=20, m_err=1 (runt).
- Odd nibble count (dv drops after 129 data nibbles) -> 64 bytes out, m_err=1.
- m_ready=0 for whole 64-byte frame -> 16 entries queued, overflow=1, later frame with m_ready=1 delivered normally, overflow stays 1.
- Preamble broken by 0x3 before SFD -> no output; next good frame received intact.
